// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file and a parallel local register port.
// Bus events come from synchronised SCL/SDA. No clock stretching. 7-bit addressing only.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned NUM_REGS    = 16,
    localparam int unsigned AW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          busy,
    input  logic [AW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    input  logic          loc_we,
    output logic [7:0]    loc_rdata,
    output logic          i2c_wr_pulse,
    output logic [AW-1:0] i2c_wr_addr
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrPtr, StWrData, StWrAck, StRdData, StRdAck
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    scl_q, sda_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          sda_out_q, sda_out_d;
    logic          busy_q, busy_d;
    logic          rw_q, rw_d;
    logic          pulse_q, pulse_d;
    logic          wr_en;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    ptr_byte;

    // [1] is the synchronised level, [2] the previous level for edge detection.
    logic scl, sda, scl_rise, scl_fall, start_det, stop_det, byte_done, rx_shift;
    assign scl       = scl_q[1];
    assign sda       = sda_q[1];
    assign scl_rise  = scl & ~scl_q[2];
    assign scl_fall  = ~scl & scl_q[2];
    assign start_det = scl & scl_q[2] & sda_q[2] & ~sda;
    assign stop_det  = scl & scl_q[2] & ~sda_q[2] & sda;
    assign rx_shift  = scl_rise && (cnt_q < 4'd8);
    assign byte_done = scl_fall && (cnt_q == 4'd8);
    assign ptr_byte  = regs_q[ptr_q];

    assign sda_o        = sda_out_q;
    assign busy         = busy_q;
    assign loc_rdata    = regs_q[loc_addr];
    assign i2c_wr_pulse = pulse_q;
    assign i2c_wr_addr  = wr_addr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        sda_out_d = sda_out_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        pulse_d   = 1'b0;
        wr_en     = 1'b0;
        if (start_det) begin
            state_d   = StAddr;
            cnt_d     = 4'd0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            cnt_d     = 4'd0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr, StWrPtr, StWrData: begin
                    if (rx_shift) begin
                        rx_d  = {rx_q[6:0], sda};
                        cnt_d = cnt_q + 4'd1;
                    end else if (byte_done) begin
                        cnt_d = 4'd0;
                        if (state_q == StAddr) begin
                            if (rx_q[7:1] == TARGET_ADDR) begin
                                sda_out_d = 1'b0;
                                busy_d    = 1'b1;
                                rw_d      = rx_q[0];
                                state_d   = StAddrAck;
                            end else begin
                                sda_out_d = 1'b1;
                                state_d   = StIdle;
                            end
                        end else begin
                            if (state_q == StWrPtr) begin
                                ptr_d = rx_q[AW-1:0];
                            end else begin
                                wr_en     = 1'b1;
                                pulse_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                ptr_d     = ptr_q + 1'b1;
                            end
                            sda_out_d = 1'b0;
                            state_d   = StWrAck;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!rw_q) begin
                            sda_out_d = 1'b1;
                            cnt_d     = 4'd0;
                            state_d   = StWrPtr;
                        end else begin
                            sda_out_d = ptr_byte[7];
                            tx_d      = {ptr_byte[6:0], 1'b0};
                            cnt_d     = 4'd1;
                            state_d   = StRdData;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        sda_out_d = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = StWrData;
                    end
                end
                StRdData: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_out_d = 1'b1;
                            cnt_d     = 4'd0;
                            state_d   = StRdAck;
                        end else begin
                            sda_out_d = tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            cnt_d     = cnt_q + 4'd1;
                        end
                    end
                end
                StRdAck: begin
                    // cnt_q==1 marks that the initiator ACKed and the next byte is due.
                    if (scl_rise) begin
                        if (!sda) begin
                            ptr_d = ptr_q + 1'b1;
                            cnt_d = 4'd1;
                        end else begin
                            busy_d    = 1'b0;
                            sda_out_d = 1'b1;
                            state_d   = StIdle;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        sda_out_d = ptr_byte[7];
                        tx_d      = {ptr_byte[6:0], 1'b0};
                        cnt_d     = 4'd1;
                        state_d   = StRdData;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            rx_q      <= 8'd0;
            tx_q      <= 8'd0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            scl_q     <= {scl_q[1:0], scl_i};
            sda_q     <= {sda_q[1:0], sda_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            sda_out_q <= sda_out_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            pulse_q   <= pulse_d;
        end
    end

    // The I2C commit is assigned last so it wins a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'd0;
            end
        end else begin
            if (loc_we) begin
                regs_q[loc_addr] <= loc_wdata;
            end
            if (wr_en) begin
                regs_q[ptr_q] <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a timed I2C initiator model plus local-port checks.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_o;
    logic       busy;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_wdata = 8'd0;
    logic       loc_we = 1'b0;
    logic [7:0] loc_rdata;
    logic       i2c_wr_pulse;
    logic [3:0] i2c_wr_addr;
    logic       sda_line;

    int compared = 0;
    int mismatched = 0;
    logic [3:0] pulses[$];

    assign sda_line = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_regs #(.TARGET_ADDR(7'h42), .NUM_REGS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl_m),
        .sda_i        (sda_line),
        .sda_o        (sda_o),
        .busy         (busy),
        .loc_addr     (loc_addr),
        .loc_wdata    (loc_wdata),
        .loc_we       (loc_we),
        .loc_rdata    (loc_rdata),
        .i2c_wr_pulse (i2c_wr_pulse),
        .i2c_wr_addr  (i2c_wr_addr)
    );

    always @(negedge clk) begin
        if (i2c_wr_pulse) pulses.push_back(i2c_wr_addr);
    end

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; #T;
        sda_m = 1'b0; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b0; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b1; #T;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #T;
        scl_m = 1'b1; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #(T/2);
        b = sda_line; #(T/2);
        scl_m = 1'b0; #T;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic reg_peek(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a; #1;
        d = loc_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        compared++; if (sda_o !== 1'b1) begin mismatched++; $display("FAIL reset_sda got %b want 1", sda_o); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (i2c_wr_pulse !== 1'b0 || i2c_wr_addr !== 4'd0) begin
            mismatched++; $display("FAIL reset_wr got %b/%h want 0/0", i2c_wr_pulse, i2c_wr_addr);
        end
        reg_peek(4'd7, d);
        compared++; if (d !== 8'h00) begin mismatched++; $display("FAIL reset_reg got %h want 00", d); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0] d;
        logic [7:0] bytes [4] = '{8'h84, 8'h03, 8'hA5, 8'h5A};
        pulses.delete();
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], ack);
            compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL wr_ack%0d got %b want 0", i, ack); end
            if (i == 0) begin
                compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL wr_busy got %b want 1", busy); end
            end
        end
        i2c_stop();
        #(T);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL wr_busy_stop got %b want 0", busy); end
        reg_peek(4'd3, d);
        compared++; if (d !== 8'hA5) begin mismatched++; $display("FAIL wr_reg3 got %h want a5", d); end
        reg_peek(4'd4, d);
        compared++; if (d !== 8'h5A) begin mismatched++; $display("FAIL wr_reg4 got %h want 5a", d); end
        compared++; if (pulses.size() != 2) begin
            mismatched++; $display("FAIL wr_pulses got %0d want 2", pulses.size());
        end else begin
            compared++; if (pulses[0] !== 4'd3 || pulses[1] !== 4'd4) begin
                mismatched++; $display("FAIL wr_pulse_addr got %h,%h want 3,4", pulses[0], pulses[1]);
            end
        end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d0, d1;
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h03, ack);
        i2c_rstart();
        write_byte(8'h85, ack);
        compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL rd_addr_ack got %b want 0", ack); end
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        compared++; if (d0 !== 8'hA5) begin mismatched++; $display("FAIL rd_byte0 got %h want a5", d0); end
        compared++; if (d1 !== 8'h5A) begin mismatched++; $display("FAIL rd_byte1 got %h want 5a", d1); end
        compared++; if (sda_o !== 1'b1) begin mismatched++; $display("FAIL rd_nack_sda got %b want 1", sda_o); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rd_nack_busy got %b want 0", busy); end
        i2c_stop();
    endtask

    task automatic test_nack_addr();
        logic ack;
        logic [7:0] d;
        pulses.delete();
        i2c_start();
        write_byte(8'hA0, ack);
        compared++; if (ack !== 1'b1) begin mismatched++; $display("FAIL nack_ack got %b want 1", ack); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL nack_busy got %b want 0", busy); end
        write_byte(8'h12, ack);
        i2c_stop();
        compared++; if (pulses.size() != 0) begin
            mismatched++; $display("FAIL nack_pulses got %0d want 0", pulses.size());
        end
        reg_peek(4'd3, d);
        compared++; if (d !== 8'hA5) begin mismatched++; $display("FAIL nack_reg3 got %h want a5", d); end
    endtask

    task automatic test_wrap();
        logic ack;
        logic [7:0] d;
        // Concurrent local writes to an unrelated index must coexist with I2C commits.
        @(negedge clk);
        loc_addr = 4'd8; loc_wdata = 8'h3C; loc_we = 1'b1;
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h0F, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        i2c_stop();
        @(negedge clk);
        loc_we = 1'b0;
        reg_peek(4'd15, d);
        compared++; if (d !== 8'h11) begin mismatched++; $display("FAIL wrap_reg15 got %h want 11", d); end
        reg_peek(4'd0, d);
        compared++; if (d !== 8'h22) begin mismatched++; $display("FAIL wrap_reg0 got %h want 22", d); end
        reg_peek(4'd8, d);
        compared++; if (d !== 8'h3C) begin mismatched++; $display("FAIL wrap_loc8 got %h want 3c", d); end
    endtask

    task automatic test_stop_mid_byte();
        logic ack;
        logic [7:0] d;
        pulses.delete();
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h05, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        #(T);
        compared++; if (pulses.size() != 0) begin
            mismatched++; $display("FAIL mid_pulses got %0d want 0", pulses.size());
        end
        compared++; if (sda_o !== 1'b1) begin mismatched++; $display("FAIL mid_sda got %b want 1", sda_o); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy got %b want 0", busy); end
        reg_peek(4'd5, d);
        compared++; if (d !== 8'h00) begin mismatched++; $display("FAIL mid_reg5 got %h want 00", d); end
        @(negedge clk);
        loc_addr = 4'd3; loc_wdata = 8'h77; loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        reg_peek(4'd3, d);
        compared++; if (d !== 8'h77) begin mismatched++; $display("FAIL loc_wr3 got %h want 77", d); end
    endtask

    task automatic test_reset_mid_ack();
        logic ack;
        logic [7:0] d;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(d_addr(i));
        compared++; if (sda_o !== 1'b0) begin mismatched++; $display("FAIL rst_pre_ack got %b want 0", sda_o); end
        rst_n = 1'b0; #1;
        compared++; if (sda_o !== 1'b1) begin mismatched++; $display("FAIL rst_async_sda got %b want 1", sda_o); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_async_busy got %b want 0", busy); end
        reg_peek(4'd3, d);
        compared++; if (d !== 8'h00) begin mismatched++; $display("FAIL rst_regs got %h want 00", d); end
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        i2c_stop();
        i2c_start();
        write_byte(8'h84, ack);
        compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL rst_new_ack got %b want 0", ack); end
        write_byte(8'h02, ack);
        write_byte(8'h99, ack);
        i2c_stop();
        reg_peek(4'd2, d);
        compared++; if (d !== 8'h99) begin mismatched++; $display("FAIL rst_new_reg2 got %h want 99", d); end
    endtask

    function automatic logic d_addr(input int i);
        logic [7:0] a;
        a = 8'h84;
        return a[i];
    endfunction

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack_addr();
        test_wrap();
        test_stop_mid_byte();
        test_reset_mid_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
